// File: rtl/axil_pkg.sv
// Shared response codes and channel FSM state encodings for the AXI4-Lite register slave.
package axil_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;
endpackage

// File: rtl/axil_reg_bank.sv
// NUM_REGS x 32-bit register storage: one byte-strobed write port, one async read port.
module axil_reg_bank #(
   parameter int NUM_REGS = 16,
   parameter int IW       = 4
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     we_i,
   input  logic [IW-1:0]            widx_i,
   input  logic [31:0]              wdata_i,
   input  logic [3:0]               wstrb_i,
   input  logic [IW-1:0]            ridx_i,
   output logic [31:0]              rdata_o,
   output logic [32*NUM_REGS-1:0]   regs_flat_o
);
   logic [NUM_REGS-1:0][31:0] regs_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         regs_q <= '0;
      end else if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) regs_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o     = regs_q[ridx_i];
   assign regs_flat_o = regs_q;
endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write/read channel FSMs over axil_reg_bank.
// Define AXIL_REG_SLAVE_DECERR_EN to answer out-of-range accesses with SLVERR.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int BASE       = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic [2:0]              s_awprot,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [31:0]             s_wdata,
   input  logic [3:0]              s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic [2:0]              s_arprot,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [31:0]             s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [32*NUM_REGS-1:0]  regs_flat,
   output logic                    wr_pulse,
   output logic [7:0]              wr_index
);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE);
   localparam logic [ADDR_WIDTH-1:0] NREG_A = ADDR_WIDTH'(NUM_REGS);
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

   wstate_e               wstate_q, wstate_d;
   rstate_e               rstate_q, rstate_d;
   logic                  rdy_q;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic                  wr_pulse_q, wr_pulse_d;
   logic [7:0]            wr_index_q, wr_index_d;
   logic [31:0]           rdata_q, rdata_d, bank_rdata;
   logic                  bank_we;

   // Extra top bit is the borrow of addr - BASE: set means addr is below BASE.
   logic [ADDR_WIDTH:0]   w_diff, r_diff;
   logic                  w_ok, r_ok;
   assign w_diff = {1'b0, awaddr_q} - {1'b0, BASE_A};
   assign r_diff = {1'b0, s_araddr} - {1'b0, BASE_A};
   assign w_ok   = !w_diff[ADDR_WIDTH] && ((w_diff[ADDR_WIDTH-1:0] >> 2) < NREG_A);
   assign r_ok   = !r_diff[ADDR_WIDTH] && ((r_diff[ADDR_WIDTH-1:0] >> 2) < NREG_A);

   logic unused_bits;
   assign unused_bits = ^{s_awprot, s_arprot, w_diff[1:0], r_diff[1:0]};

   assign s_awready = rdy_q && (wstate_q == W_IDLE) && !aw_held_q;
   assign s_wready  = rdy_q && (wstate_q == W_IDLE) && !w_held_q;
   assign s_arready = rdy_q && (rstate_q == R_IDLE);

   always_comb begin
      wstate_d   = wstate_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = 1'b0;
      wr_index_d = wr_index_q;
      bank_we    = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (s_awvalid && s_awready) begin
               aw_held_d = 1'b1;
               awaddr_d  = s_awaddr;
            end
            if (s_wvalid && s_wready) begin
               w_held_d = 1'b1;
               wdata_d  = s_wdata;
               wstrb_d  = s_wstrb;
            end
            if (aw_held_q && w_held_q) begin
               bank_we    = w_ok;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_pulse_d = 1'b1;
               wr_index_d = w_ok ? 8'(w_diff[ADDR_WIDTH-1:0] >> 2) : 8'hFF;
               bvalid_d   = 1'b1;
               bresp_d    = w_ok ? RESP_OKAY : ERR_RESP;
               wstate_d   = W_RESP;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               bvalid_d = 1'b0;
               wstate_d = W_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rstate_d = rstate_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         R_IDLE: begin
            if (s_arvalid && s_arready) begin
               rvalid_d = 1'b1;
               rdata_d  = r_ok ? bank_rdata : 32'h0;
               rresp_d  = r_ok ? RESP_OKAY : ERR_RESP;
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_rready) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wstate_q   <= W_IDLE;
         rstate_q   <= R_IDLE;
         rdy_q      <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= 1'b0;
         wr_index_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wstate_q   <= wstate_d;
         rstate_q   <= rstate_d;
         rdy_q      <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         wr_index_q <= wr_index_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   axil_reg_bank #(.NUM_REGS(NUM_REGS), .IW(IW)) u_bank (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .we_i        (bank_we),
      .widx_i      (w_diff[IW+1:2]),
      .wdata_i     (wdata_q),
      .wstrb_i     (wstrb_q),
      .ridx_i      (r_diff[IW+1:2]),
      .rdata_o     (bank_rdata),
      .regs_flat_o (regs_flat)
   );

   assign s_bvalid = bvalid_q;
   assign s_bresp  = bresp_q;
   assign s_rvalid = rvalid_q;
   assign s_rdata  = rdata_q;
   assign s_rresp  = rresp_q;
   assign wr_pulse = wr_pulse_q;
   assign wr_index = wr_index_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed plus randomized bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;
   localparam int          NR   = 16;
   localparam logic [31:0] BASE = 32'h1000;
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0]  EXP_ERR = 2'b10;
`else
   localparam logic [1:0]  EXP_ERR = 2'b00;
`endif

   logic            clk = 1'b0, rstn = 1'b0;
   logic [31:0]     s_awaddr = '0, s_araddr = '0, s_wdata = '0;
   logic [2:0]      s_awprot = '0, s_arprot = '0;
   logic [3:0]      s_wstrb = '0;
   logic            s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
   logic            s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_pulse;
   logic [1:0]      s_bresp, s_rresp;
   logic [31:0]     s_rdata;
   logic [32*NR-1:0] regs_flat;
   logic [7:0]      wr_index;

   axil_reg_slave #(.ADDR_WIDTH(32), .NUM_REGS(NR), .BASE(32'h1000)) dut (
      .clk(clk), .rstn(rstn),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_index(wr_index)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [31:0] model [NR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      if (off < 0 || (off / 4) >= NR) return -1;
      return int'(off / 4);
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      i = idx_of(a);
      if (i < 0) return;
      for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic chk_regs(input string tag);
      for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), regs_flat[32*i +: 32], model[i]);
   endtask

   // lead > 0: W presented lead cycles before AW; lead < 0: AW first. Leaves bvalid pending.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output logic [1:0] resp, output logic [7:0] pidx,
                            output int npulse, output int lat);
      bit aw_done, w_done, aw_hs, w_hs;
      int cyc, hs_cyc;
      aw_done = 0; w_done = 0; cyc = 0; hs_cyc = -1;
      npulse = 0; pidx = 8'h00; lat = -1; resp = 2'bxx;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      while (cyc < 40) begin
         s_wvalid  = !w_done  && (cyc >= ((lead < 0) ? -lead : 0));
         s_awvalid = !aw_done && (cyc >= ((lead > 0) ? lead : 0));
         aw_hs = s_awvalid && s_awready;
         w_hs  = s_wvalid && s_wready;
         @(posedge clk); #1; cyc++;
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
         if ((aw_hs || w_hs) && aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
         if (wr_pulse) begin npulse++; pidx = wr_index; end
         if (s_bvalid) begin lat = cyc - hs_cyc; resp = s_bresp; break; end
      end
      s_awvalid = 0; s_wvalid = 0;
   endtask

   task automatic b_accept(input int hold, input logic [1:0] exp_resp, input string tag);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk({tag, "_bvalid_hold"}, 32'(s_bvalid), 32'd1);
         chk({tag, "_bresp_hold"}, 32'(s_bresp), 32'(exp_resp));
         chk({tag, "_awready_busy"}, 32'(s_awready), 32'd0);
         chk({tag, "_pulse_once"}, 32'(wr_pulse), 32'd0);
      end
      s_bready = 1;
      @(posedge clk); #1;
      s_bready = 0;
      chk({tag, "_bvalid_drop"}, 32'(s_bvalid), 32'd0);
      chk({tag, "_awready_back"}, 32'(s_awready), 32'd1);
      chk({tag, "_wready_back"}, 32'(s_wready), 32'd1);
      chk({tag, "_pulse_gone"}, 32'(wr_pulse), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int hold, input string tag);
      logic [1:0] resp; logic [7:0] pidx; int np, lat, i;
      i = idx_of(addr);
      axi_write(addr, data, strb, lead, resp, pidx, np, lat);
      model_write(addr, data, strb);
      chk({tag, "_blat"}, 32'(lat), 32'd1);
      chk({tag, "_npulse"}, 32'(np), 32'd1);
      chk({tag, "_wr_index"}, 32'(pidx), (i < 0) ? 32'hFF : 32'(i));
      chk({tag, "_bresp"}, 32'(resp), (i < 0) ? 32'(EXP_ERR) : 32'd0);
      b_accept(hold, (i < 0) ? EXP_ERR : 2'b00, tag);
      chk_regs(tag);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
      bit h; int cyc, hs_cyc;
      cyc = 0; hs_cyc = -1; data = 'x; resp = 'x; lat = -1;
      s_araddr = addr; s_arvalid = 1;
      while (cyc < 40) begin
         h = s_arvalid && s_arready;
         @(posedge clk); #1; cyc++;
         if (h) begin s_arvalid = 0; hs_cyc = cyc; end
         if (s_rvalid) begin data = s_rdata; resp = s_rresp; lat = cyc - hs_cyc; break; end
      end
      s_arvalid = 0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
      logic [31:0] d, ed; logic [1:0] r, er; int lat, i;
      i  = idx_of(addr);
      ed = (i < 0) ? 32'h0 : model[i];
      er = (i < 0) ? EXP_ERR : 2'b00;
      axi_read(addr, d, r, lat);
      chk({tag, "_rlat"}, 32'(lat), 32'd0);
      chk({tag, "_rdata"}, d, ed);
      chk({tag, "_rresp"}, 32'(r), 32'(er));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk({tag, "_rvalid_hold"}, 32'(s_rvalid), 32'd1);
         chk({tag, "_rdata_hold"}, s_rdata, ed);
         chk({tag, "_arready_busy"}, 32'(s_arready), 32'd0);
      end
      s_rready = 1;
      @(posedge clk); #1;
      s_rready = 0;
      chk({tag, "_rvalid_drop"}, 32'(s_rvalid), 32'd0);
      chk({tag, "_arready_back"}, 32'(s_arready), 32'd1);
   endtask

   initial begin
      logic [31:0] a, d; logic [1:0] r; logic [7:0] px; int np, lat;
      for (int i = 0; i < NR; i++) model[i] = '0;

      // Reset and release.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 32'(s_awready), 32'd0);
      chk("rst_wready", 32'(s_wready), 32'd0);
      chk("rst_arready", 32'(s_arready), 32'd0);
      chk("rst_bvalid", 32'(s_bvalid), 32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      chk("rst_wr_index", 32'(wr_index), 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
      chk_regs("rst");
      rstn = 1; #1;
      chk("rel_awready_pre", 32'(s_awready), 32'd0);
      @(posedge clk); #1;
      chk("rel_awready", 32'(s_awready), 32'd1);
      chk("rel_wready", 32'(s_wready), 32'd1);
      chk("rel_arready", 32'(s_arready), 32'd1);

      // Directed cases.
      do_write(32'h1008, 32'hA5A5A5A5, 4'hF, 0, 1, "wr_same");
      chk("wr_same_reg2", regs_flat[64 +: 32], 32'hA5A5A5A5);
      do_write(32'h1004, 32'h11223344, 4'h5, 3, 1, "wr_wfirst");
      chk("wr_wfirst_reg1", regs_flat[32 +: 32], 32'h00220044);
      do_read(32'h1008, 5, "rd_hold");
      do_write(32'h1040, 32'hFFFFFFFF, 4'hF, 0, 1, "wr_oor");
      do_read(32'h0FFC, 1, "rd_oor");
      do_write(32'h1003, 32'hCAFEF00D, 4'hC, -2, 2, "wr_awfirst");

      // Randomized mix of reads and writes.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0: a = BASE - 32'(4 * $urandom_range(1, 4));
               1: a = BASE + 32'(4 * NR) + 32'($urandom_range(0, 400));
               2: a = 32'hFFFFFFFC;
               default: a = 32'h0;
            endcase
         end else begin
            a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 9) < 6)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                     $urandom_range(0, 2), $sformatf("rnd%0d_wr", n));
         else
            do_read(a, $urandom_range(0, 2), $sformatf("rnd%0d_rd", n));
      end

      // Reset with both responses pending.
      axi_write(32'h1010, 32'hDEADBEEF, 4'hF, 0, r, px, np, lat);
      axi_read(32'h1008, d, r, lat);
      chk("mid_bvalid_pend", 32'(s_bvalid), 32'd1);
      chk("mid_rvalid_pend", 32'(s_rvalid), 32'd1);
      #2; rstn = 0; #1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      chk("mid_bvalid_drop", 32'(s_bvalid), 32'd0);
      chk("mid_rvalid_drop", 32'(s_rvalid), 32'd0);
      chk("mid_arready_drop", 32'(s_arready), 32'd0);
      chk_regs("mid_rst");
      @(negedge clk); rstn = 1;
      @(posedge clk); #1;
      do_read(32'h1008, 0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
